code_memory_loader: RTL and testbench

//  Parametrised instruction memory for the CPU datapath, next generation of our fixed 16x64 code store.

---
 rtl/codemem_pkg.sv | 16 +
 rtl/code_memory_loader_if.sv | 43 ++++
 rtl/codemem_array.sv | 56 +++++
 rtl/code_memory_loader.sv | 145 ++++++++++++++
 tb/tb_code_memory_loader.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/codemem_pkg.sv
// Shared definitions for the code memory loader: FSM state encoding,
// the NOOP word used to clear the array and the default boot instruction.
package codemem_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [15:0] NOOP_WORD     = 16'h0000;
  localparam logic [15:0] BOOT_INSN_DEF = 16'hE01E;  // jump to program base
  localparam int          BOOT_ADDR_DEF = 1;

endpackage

// File: rtl/code_memory_loader_if.sv
// Bus bundle of the code memory loader: fetch port, CPU write port and the
// streaming program-load port. The slave side is the memory, the master side
// is whoever drives fetches, stores and load bursts.
interface code_memory_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);

  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              fetch_perr;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_drop;

  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              busy;

  modport master (
    output fetch_en, fetch_addr, wr_en, wr_addr, wr_data,
           ld_start, ld_base, ld_len, ld_valid, ld_data,
    input  fetch_data, fetch_valid, fetch_perr, wr_drop,
           ld_ready, ld_done, busy
  );

  modport slave (
    input  fetch_en, fetch_addr, wr_en, wr_addr, wr_data,
           ld_start, ld_base, ld_len, ld_valid, ld_data,
    output fetch_data, fetch_valid, fetch_perr, wr_drop,
           ld_ready, ld_done, busy
  );

endinterface

// File: rtl/codemem_array.sv
// Code store array: one write port, one registered read port with write-first
// bypass. With CODEMEM_PARITY_EN defined each word carries an even-parity bit
// and the read port reports a mismatch; otherwise o_perr is tied low.
module codemem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_perr
);

  localparam int DEPTH = 1 << ADDR_W;

  // NOTE: the storage array has no reset; the INIT sweep rewrites every word,
  // which keeps the array mappable onto plain RAM.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_hit;

  assign w_hit = i_we && (i_waddr == i_raddr);

  // Word storage write
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; a same-cycle write to the fetched address wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    o_rdata <= '0;
    else if (i_re) o_rdata <= w_hit ? i_wdata : r_mem[i_raddr];
  end

`ifdef CODEMEM_PARITY_EN
  logic r_par [DEPTH];

  // Parity storage write, every write including the INIT sweep
  always_ff @(posedge clk) begin
    if (i_we) r_par[i_waddr] <= ^i_wdata;
  end

  // Parity check of the fetched word; bypassed data is fresh and always clean
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    o_perr <= 1'b0;
    else if (i_re) o_perr <= w_hit ? 1'b0 : (r_par[i_raddr] != (^r_mem[i_raddr]));
  end
`else
  assign o_perr = 1'b0;
`endif

endmodule

// File: rtl/code_memory_loader.sv
// Parametrised instruction memory with self-initialisation, registered fetch,
// CPU write port and a valid/ready program-load port.
// Optional parity per word: define CODEMEM_PARITY_EN.
module code_memory_loader
  import codemem_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 6,
  parameter int                BOOT_ADDR = BOOT_ADDR_DEF,
  parameter logic [DATA_W-1:0] BOOT_INSN = BOOT_INSN_DEF
) (
  input logic                  clk,
  input logic                  reset,
  code_memory_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] BOOT_A  = ADDR_W'(BOOT_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = '1;
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_init_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_cnt;
  logic              r_ld_ready;
  logic              r_ld_done;
  logic              r_busy;
  logic              r_wr_drop;
  logic              r_fetch_valid;

  logic              w_ld_fire;
  logic              w_re;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_perr;

  assign w_ld_fire = (r_state == ST_LOAD) && r_ld_ready && bus.ld_valid;
  assign w_re      = bus.fetch_en && (r_state != ST_INIT);

  // Write-port owner: INIT sweep, then the loader, then the CPU (IDLE only)
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_we    = 1'b0;
    w_waddr = bus.wr_addr;
    w_wdata = bus.wr_data;
    case (r_state)
      ST_INIT: begin
        w_we    = 1'b1;
        w_waddr = r_init_ptr;
        w_wdata = (r_init_ptr == BOOT_A) ? BOOT_INSN : NOOP_WORD;
      end
      ST_LOAD: begin
        w_we    = w_ld_fire;
        w_waddr = r_ptr;
        w_wdata = bus.ld_data;
      end
      ST_IDLE: w_we = bus.wr_en;
      default: w_we = 1'b0;
    endcase
  end

  // Control FSM with counters and registered status outputs
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_INIT;
      r_init_ptr    <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_ld_ready    <= 1'b0;
      r_ld_done     <= 1'b0;
      r_busy        <= 1'b1;
      r_wr_drop     <= 1'b0;
      r_fetch_valid <= 1'b0;
    end else begin
      r_fetch_valid <= w_re;
      r_ld_done     <= 1'b0;
      if (bus.wr_en && (r_state != ST_IDLE)) r_wr_drop <= 1'b1;
      case (r_state)
        ST_INIT: begin
          r_init_ptr <= r_init_ptr + 1'b1;
          if (r_init_ptr == LAST_A) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.ld_start) begin
            r_busy <= 1'b1;
            if (bus.ld_len != '0) begin
              r_state    <= ST_LOAD;
              r_ptr      <= bus.ld_base;
              r_cnt      <= bus.ld_len;
              r_ld_ready <= 1'b1;
            end else begin
              r_state   <= ST_DONE;
              r_ld_done <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_ld_fire) begin
            r_ptr <= r_ptr + 1'b1;  // wraps DEPTH-1 -> 0
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_ONE) begin
              r_state    <= ST_DONE;
              r_ld_ready <= 1'b0;
              r_ld_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  codemem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (bus.fetch_addr),
    .o_rdata (bus.fetch_data),
    .o_perr  (w_perr)
  );

  assign bus.fetch_valid = r_fetch_valid;
  assign bus.fetch_perr  = w_perr & r_fetch_valid;
  assign bus.wr_drop     = r_wr_drop;
  assign bus.ld_ready    = r_ld_ready;
  assign bus.ld_done     = r_ld_done;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_code_memory_loader.sv
// Directed testbench for code_memory_loader. Fetch expectations go into a
// queue when a fetch is issued; a negedge monitor pops and compares them
// whenever fetch_valid is presented.
module tb_code_memory_loader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  code_memory_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  code_memory_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        perr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] model [DEPTH];
  logic [15:0] ld_words [8];
  int          n_vec    = 0;
  int          n_err    = 0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
    model[1] = 16'hE01E;
  endtask

  task automatic idle_inputs();
    bus.fetch_en   = 1'b0;
    bus.fetch_addr = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.ld_start   = 1'b0;
    bus.ld_base    = '0;
    bus.ld_len     = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = '0;
  endtask

  task automatic fetch(input int a, input logic perr);
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = 6'(a);
    exp_q.push_back('{data: model[a], perr: perr});
    tick();
    bus.fetch_en = 1'b0;
  endtask

  task automatic wait_not_busy(input int max_cycles);
    int c = 0;
    while (bus.busy && c < max_cycles) begin
      tick();
      c++;
    end
    check("busy_fall_timeout", 32'(bus.busy), 32'd0);
  endtask

  // Burst of len words from ld_words; ld_valid drops in cycle gap_at; in cycle
  // disturb_at a CPU store to addr 5 and a fetch of the word being loaded are
  // issued alongside the load beat.
  task automatic load_burst(input int base, input int len, input int gap_at, input int disturb_at);
    int i   = 0;
    int cyc = 0;
    int a;
    bus.ld_start = 1'b1;
    bus.ld_base  = 6'(base);
    bus.ld_len   = 7'(len);
    tick();
    bus.ld_start = 1'b0;
    check("ld_ready_in_load", 32'(bus.ld_ready), 32'd1);
    check("busy_in_load", 32'(bus.busy), 32'd1);
    while (i < len && cyc < 40) begin
      a = (base + i) % DEPTH;
      if (cyc == gap_at) bus.ld_valid = 1'b0;
      else begin
        bus.ld_valid = 1'b1;
        bus.ld_data  = ld_words[i];
      end
      if (cyc == disturb_at && bus.ld_valid) begin
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 6'd5;
        bus.wr_data    = 16'hBAD5;
        model[a]       = ld_words[i];
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 6'(a);
        exp_q.push_back('{data: model[a], perr: 1'b0});
      end
      tick();
      bus.wr_en    = 1'b0;
      bus.fetch_en = 1'b0;
      if (bus.ld_valid) begin
        model[a] = ld_words[i];
        i++;
      end
      bus.ld_valid = 1'b0;
      cyc++;
    end
    check("ld_done_pulse", 32'(bus.ld_done), 32'd1);
    check("ld_ready_in_done", 32'(bus.ld_ready), 32'd0);
    check("busy_in_done", 32'(bus.busy), 32'd1);
    tick();
    check("ld_done_single", 32'(bus.ld_done), 32'd0);
    check("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.fetch_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_fetch_valid: got data %h, expected no fetch (t=%0t)",
                 bus.fetch_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("fetch_data", 32'(bus.fetch_data), 32'(mon_e.data));
        check("fetch_perr", 32'(bus.fetch_perr), 32'(mon_e.perr));
      end
    end
  end

  // ld_done pulse counter
  always @(negedge clk) begin
    if (bus.ld_done === 1'b1) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    model_init();
    repeat (3) tick();

    // Reset state
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    check("rst_fetch_data", 32'(bus.fetch_data), 32'd0);
    check("rst_fetch_perr", 32'(bus.fetch_perr), 32'd0);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_ld_done", 32'(bus.ld_done), 32'd0);
    check("rst_wr_drop", 32'(bus.wr_drop), 32'd0);

    // 1. INIT takes exactly 64 cycles; fetches during INIT are ignored
    reset         = 1'b1;
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = 6'd1;
    tick();
    bus.fetch_en = 1'b0;
    check("init_fetch_ignored", 32'(bus.fetch_valid), 32'd0);
    repeat (62) tick();
    check("busy_at_63", 32'(bus.busy), 32'd1);
    tick();
    check("busy_at_64", 32'(bus.busy), 32'd0);
    check("idle_ld_ready", 32'(bus.ld_ready), 32'd0);
    fetch(0, 1'b0);
    fetch(63, 1'b0);
    fetch(1, 1'b0);
    tick();
    check("no_req_valid_low", 32'(bus.fetch_valid), 32'd0);
    check("no_req_data_hold", 32'(bus.fetch_data), 32'h0000_E01E);

    // 2. Load 32..34 with a ld_valid gap
    ld_words[0] = 16'hA0A0;
    ld_words[1] = 16'hB1B1;
    ld_words[2] = 16'hC2C2;
    load_burst(32, 3, 1, -1);
    check("done_cnt_t2", 32'(done_cnt), 32'd1);
    fetch(32, 1'b0);
    fetch(33, 1'b0);
    fetch(34, 1'b0);

    // Zero-length burst: straight to DONE, nothing written
    bus.ld_start = 1'b1;
    bus.ld_base  = 6'd1;
    bus.ld_len   = 7'd0;
    tick();
    bus.ld_start = 1'b0;
    check("len0_ld_done", 32'(bus.ld_done), 32'd1);
    check("len0_ld_ready", 32'(bus.ld_ready), 32'd0);
    tick();
    check("len0_busy_after", 32'(bus.busy), 32'd0);
    check("done_cnt_len0", 32'(done_cnt), 32'd2);
    fetch(1, 1'b0);

    // 3. Wrapping burst 62, 63, 0, 1
    ld_words[0] = 16'hD1D1;
    ld_words[1] = 16'hE2E2;
    ld_words[2] = 16'hF3F3;
    ld_words[3] = 16'h0707;
    load_burst(62, 4, -1, -1);
    fetch(62, 1'b0);
    fetch(63, 1'b0);
    fetch(0, 1'b0);
    fetch(1, 1'b0);
    check("wr_drop_still_clear", 32'(bus.wr_drop), 32'd0);

    // 4. CPU write during LOAD is dropped; loader write-first on fetch
    ld_words[0] = 16'h4444;
    ld_words[1] = 16'h5555;
    load_burst(40, 2, -1, 1);
    check("wr_drop_set", 32'(bus.wr_drop), 32'd1);
    fetch(5, 1'b0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 6'd5;
    bus.wr_data = 16'h5A5A;
    model[5]    = 16'h5A5A;
    tick();
    bus.wr_en = 1'b0;
    fetch(5, 1'b0);
    fetch(40, 1'b0);
    fetch(41, 1'b0);
    check("wr_drop_sticky", 32'(bus.wr_drop), 32'd1);
    check("done_cnt_t4", 32'(done_cnt), 32'd4);

    // 5. Same-cycle CPU write and fetch of addr 9
    bus.wr_en      = 1'b1;
    bus.wr_addr    = 6'd9;
    bus.wr_data    = 16'h1234;
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = 6'd9;
    model[9]       = 16'h1234;
    exp_q.push_back('{data: 16'h1234, perr: 1'b0});
    tick();
    bus.wr_en    = 1'b0;
    bus.fetch_en = 1'b0;
    fetch(9, 1'b0);

    // 6. Reset mid-LOAD aborts the burst and re-clears the array
    bus.ld_start = 1'b1;
    bus.ld_base  = 6'd20;
    bus.ld_len   = 7'd5;
    tick();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'h1111;
    tick();
    bus.ld_data = 16'h2222;
    tick();
    reset        = 1'b0;
    bus.ld_valid = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd1);
    check("abort_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("abort_wr_drop", 32'(bus.wr_drop), 32'd0);
    check("abort_fetch_data", 32'(bus.fetch_data), 32'd0);
    repeat (2) tick();
    model_init();
    reset = 1'b1;
    repeat (40) tick();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 6'd0;
    bus.wr_data = 16'hFFFF;
    tick();
    bus.wr_en = 1'b0;
    check("init_wr_drop", 32'(bus.wr_drop), 32'd1);
    wait_not_busy(100);
    for (int a = 0; a < DEPTH; a++) fetch(a, 1'b0);
    check("done_cnt_after_abort", 32'(done_cnt), 32'd4);

`ifdef CODEMEM_PARITY_EN
    dut.u_array.r_par[7] = ~dut.u_array.r_par[7];
    fetch(7, 1'b1);
    fetch(6, 1'b0);
`endif

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
